// File: rtl/tdes_pkg.sv
// tdes_pkg: shared widths, DES key-schedule tables (PC1, PC2, SHIFT), FSM
// state enum and small helpers for the Triple DES key scheduler.
// Table entries use DES bit numbering (1 = MSB).
package tdes_pkg;

  localparam int KEY_W    = 64;
  localparam int HALF_W   = 28;
  localparam int CD_W     = 2 * HALF_W;
  localparam int SUBKEY_W = 48;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2
  } state_t;

  localparam logic [5:0] PC1 [CD_W] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [5:0] PC2 [SUBKEY_W] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // Per-round left-shift amounts of the forward schedule.
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Rotations only ever move by 1 or 2 positions.
  function automatic logic [HALF_W-1:0] rol28(input logic [HALF_W-1:0] x,
                                              input logic [1:0] n);
    return (n == 2'd2) ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
                       : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] ror28(input logic [HALF_W-1:0] x,
                                              input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[HALF_W-1:2]}
                       : {x[0], x[HALF_W-1:1]};
  endfunction

  // Odd parity on every byte of a DES key.
  function automatic logic key_parity_ok(input logic [KEY_W-1:0] k);
    return ^k[63:56] & ^k[55:48] & ^k[47:40] & ^k[39:32] &
           ^k[31:24] & ^k[23:16] & ^k[15:8]  & ^k[7:0];
  endfunction

endpackage

// File: rtl/des_pc2.sv
// des_pc2: combinational PC2 permutation, 56-bit C||D -> 48-bit subkey.
// Ports: cd (C in [55:28], D in [27:0]), subkey (DES bit 1 at [47]).
module des_pc2
  import tdes_pkg::*;
(
  input  logic [CD_W-1:0]     cd,
  output logic [SUBKEY_W-1:0] subkey
);

  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
    assign subkey[SUBKEY_W-1-i] = cd[CD_W-PC2[i]];
  end

endmodule

// File: rtl/tdes_key_scheduler.sv
// tdes_key_scheduler: sequential Triple DES key schedule. After a start
// pulse it streams 48 subkeys (3 passes x 16 rounds) over valid/ready,
// reversing the subkey order on decrypt passes.
// Ports: HCLK/HRESET (async, active high); enable, encryptionType,
// key1..key3 from the slave controller; subkeyReady/subkeyValid/subkey to
// the round datapath; roundNum, passNum, passDecrypt, busy, done, keyError.
// Optional: define TDES_KEY_PARITY_CHECK_EN to reject keys with bad odd
// byte parity at start (keyError sticky until the next good start).
module tdes_key_scheduler
  import tdes_pkg::*;
(
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                enable,
  input  logic                encryptionType,
  input  logic [KEY_W-1:0]    key1,
  input  logic [KEY_W-1:0]    key2,
  input  logic [KEY_W-1:0]    key3,
  input  logic                subkeyReady,
  output logic                subkeyValid,
  output logic [SUBKEY_W-1:0] subkey,
  output logic [3:0]          roundNum,
  output logic [1:0]          passNum,
  output logic                passDecrypt,
  output logic                busy,
  output logic                done,
  output logic                keyError
);

  state_t              state, state_nxt;
  logic [KEY_W-1:0]    k1_q, k2_q, k3_q, pass_key;
  logic                enc_q;
  logic [HALF_W-1:0]   c_q, d_q;
  logic [3:0]          round_q;
  logic [1:0]          pass_q;
  logic                done_q;
  logic                hs, pass_rev, start_ok;
  logic [CD_W-1:0]     load_cd;
  logic [1:0]          sh_fwd, sh_rev;

  // ---- optional key parity gate ------------------------------------------
`ifdef TDES_KEY_PARITY_CHECK_EN
  logic key_err_q;
  assign start_ok = key_parity_ok(key1) & key_parity_ok(key2) & key_parity_ok(key3);
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                          key_err_q <= 1'b0;
    else if (state == S_IDLE && enable)  key_err_q <= ~start_ok;
  end
  assign keyError = key_err_q;
`else
  assign start_ok = 1'b1;
  assign keyError = 1'b0;
`endif

  // ---- pass key / direction ----------------------------------------------
  // Encrypt is E-K1, D-K2, E-K3; decrypt is D-K3, E-K2, D-K1.
  always_comb begin
    pass_key = k2_q;
    case (pass_q)
      2'd0:    pass_key = enc_q ? k1_q : k3_q;
      2'd1:    pass_key = k2_q;
      default: pass_key = enc_q ? k3_q : k1_q;
    endcase
  end

  assign pass_rev = enc_q ? (pass_q == 2'd1) : (pass_q != 2'd1);

  for (genvar i = 0; i < CD_W; i++) begin : g_pc1
    assign load_cd[CD_W-1-i] = pass_key[KEY_W-PC1[i]];
  end

  // Forward steps to the next round's shift. Reverse undoes the shift of
  // the round just emitted: round r holds DES K(16-r), so stepping back
  // to K(15-r) rotates right by that round's amount, SHIFT[15-r].
  assign sh_fwd = SHIFT[round_q + 4'd1];
  assign sh_rev = SHIFT[4'd15 - round_q];

  assign subkeyValid = (state == S_ROUND);
  assign hs          = subkeyValid & subkeyReady;

  // ---- FSM ---------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable && start_ok) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_ROUND;
      S_ROUND: if (hs && round_q == 4'd15)
                 state_nxt = (pass_q == 2'd2) ? S_IDLE : S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- datapath ----------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      k1_q    <= '0;
      k2_q    <= '0;
      k3_q    <= '0;
      enc_q   <= 1'b0;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      pass_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (enable && start_ok) begin
          k1_q    <= key1;
          k2_q    <= key2;
          k3_q    <= key3;
          enc_q   <= encryptionType;
          pass_q  <= 2'd0;
          round_q <= 4'd0;
        end
        S_LOAD: begin
          round_q <= 4'd0;
          // Reverse passes start at K16: PC1 output is already 28 shifts in.
          if (pass_rev) begin
            c_q <= load_cd[CD_W-1:HALF_W];
            d_q <= load_cd[HALF_W-1:0];
          end else begin
            c_q <= rol28(load_cd[CD_W-1:HALF_W], SHIFT[0]);
            d_q <= rol28(load_cd[HALF_W-1:0],    SHIFT[0]);
          end
        end
        S_ROUND: if (hs) begin
          if (round_q != 4'd15) begin
            round_q <= round_q + 4'd1;
            if (pass_rev) begin
              c_q <= ror28(c_q, sh_rev);
              d_q <= ror28(d_q, sh_rev);
            end else begin
              c_q <= rol28(c_q, sh_fwd);
              d_q <= rol28(d_q, sh_fwd);
            end
          end else begin
            round_q <= 4'd0;
            if (pass_q == 2'd2) begin
              pass_q <= 2'd0;
              done_q <= 1'b1;
            end else begin
              pass_q <= pass_q + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c_q, d_q}),
    .subkey (subkey)
  );

  assign roundNum    = round_q;
  assign passNum     = pass_q;
  assign busy        = (state != S_IDLE);
  assign passDecrypt = busy & pass_rev;
  assign done        = done_q;

endmodule

// File: tb/tb_tdes_key_scheduler.sv
// tb_tdes_key_scheduler: scoreboard bench for tdes_key_scheduler. Expected
// subkeys come from an independent key-schedule model (cumulative shift
// from PC1) pushed at start and popped on each handshake.
module tb_tdes_key_scheduler;

  localparam logic [63:0] K_STD = 64'h133457799BBCDFF1;
  localparam logic [63:0] K_ONE = 64'h0101010101010101;

  localparam int PC1_M [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
    19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
    14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_M [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SH_M [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic        HCLK = 1'b0, HRESET = 1'b1, enable = 1'b0;
  logic        encryptionType = 1'b0, subkeyReady = 1'b0;
  logic [63:0] key1 = '0, key2 = '0, key3 = '0;
  logic        subkeyValid, passDecrypt, busy, done, keyError;
  logic [47:0] subkey;
  logic [3:0]  roundNum;
  logic [1:0]  passNum;

  tdes_key_scheduler dut (
    .HCLK(HCLK), .HRESET(HRESET), .enable(enable),
    .encryptionType(encryptionType), .key1(key1), .key2(key2), .key3(key3),
    .subkeyReady(subkeyReady), .subkeyValid(subkeyValid), .subkey(subkey),
    .roundNum(roundNum), .passNum(passNum), .passDecrypt(passDecrypt),
    .busy(busy), .done(done), .keyError(keyError)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0, failures = 0;
  int cyc = 0, start_cyc = 0, dc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  p;
    logic [3:0]  r;
    logic        pd;
    logic [47:0] sk;
  } exp_t;

  exp_t        sb[$];
  logic [47:0] got_sk [64];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] m_rot(input logic [27:0] x, input int n);
    logic [55:0] dbl;
    dbl = {x, x} >> (28 - n);
    return dbl[27:0];
  endfunction

  // DES subkey K(idx+1): PC1, rotate by the cumulative shift, PC2.
  function automatic logic [47:0] m_subkey(input logic [63:0] k, input int idx);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] r;
    int tot;
    tot = 0;
    for (int j = 0; j <= idx; j++) tot += SH_M[j];
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(64 - PC1_M[i])];
    c = m_rot(cd[55:28], tot);
    d = m_rot(cd[27:0], tot);
    cd = {c, d};
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_M[i])];
    return r;
  endfunction

  task automatic push_run(input logic enc, input logic [63:0] a, b, c);
    logic [63:0] k;
    logic        rev;
    exp_t        e;
    for (int p = 0; p < 3; p++) begin
      k   = (p == 1) ? b : ((p == 0) == enc) ? a : c;
      rev = enc ? (p == 1) : (p != 1);
      for (int r = 0; r < 16; r++) begin
        e.p  = 2'(p);
        e.r  = 4'(r);
        e.pd = rev;
        e.sk = m_subkey(k, rev ? 15 - r : r);
        sb.push_back(e);
      end
    end
  endtask

  task automatic start(input logic enc, input logic [63:0] a, b, c, input logic push);
    encryptionType = enc;
    key1 = a; key2 = b; key3 = c;
    enable = 1'b1;
    start_cyc = cyc + 1;
    if (push) push_run(enc, a, b, c);
    @(posedge HCLK); #1;
    enable = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge HCLK);
      if (done) begin dcyc = cyc; break; end
    end
    if (dcyc < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  // Scoreboard consumer.
  always @(negedge HCLK) begin
    if (!HRESET && subkeyValid && subkeyReady) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        chk($sformatf("subkey p%0d r%0d", sb[0].p, sb[0].r),
            64'({passNum, roundNum, passDecrypt, subkey}), 64'(sb[0]));
        got_sk[{sb[0].p, sb[0].r}] <= subkey;
        sb.pop_front();
      end
    end
  end

  logic [47:0] hold_sk, acc;
  logic [63:0] r1, r2, r3;
  int          hit;

  initial begin
    // ---- reset ----
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_ctl", 64'({subkeyValid, busy, done, passDecrypt, keyError, roundNum, passNum}), 64'd0);
    chk("rst_subkey", 64'(subkey), 64'd0);
    #1 HRESET = 1'b0;
    subkeyReady = 1'b1;
    @(posedge HCLK); #1;

    // ---- encrypt, standard key, continuous ready ----
    start(1'b1, K_STD, K_STD, K_STD, 1'b1);
    wait_done(dc);
    chk("enc_latency", 64'(dc - start_cyc), 64'd51);
    chk("enc_p0r0",  64'(got_sk[0]),  64'h1B02EFFC7072);
    chk("enc_p0r15", 64'(got_sk[15]), 64'hCB3D8B0E17F5);
    chk("enc_p1r0",  64'(got_sk[16]), 64'hCB3D8B0E17F5);
    chk("enc_p1r15", 64'(got_sk[31]), 64'h1B02EFFC7072);
    chk("enc_drain", 64'(sb.size()), 64'd0);

    // ---- decrypt, started in the done cycle ----
    start(1'b0, K_ONE, K_ONE, K_STD, 1'b1);
    chk("b2b_start", 64'({done, busy}), 64'b01);
    wait_done(dc);
    chk("dec_latency", 64'(dc - start_cyc), 64'd51);
    chk("dec_p0r0",  64'(got_sk[0]),  64'hCB3D8B0E17F5);
    chk("dec_p0r15", 64'(got_sk[15]), 64'h1B02EFFC7072);
    acc = '0;
    for (int i = 16; i < 48; i++) acc |= got_sk[i];
    chk("dec_zero_passes", 64'(acc), 64'd0);
    chk("dec_drain", 64'(sb.size()), 64'd0);

    // ---- backpressure, ignored enable, keys changed mid-run ----
    @(posedge HCLK); #1;
    r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom}; r3 = {$urandom, $urandom};
    start(1'b1, r1, r2, r3, 1'b1);
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge HCLK); #1;
      if (subkeyValid && passNum == 2'd1 && roundNum == 4'd7) begin hit = 1; break; end
    end
    chk("bp_reach", 64'(hit), 64'd1);
    hold_sk = subkey;
    subkeyReady = 1'b0;
    repeat (5) begin
      @(posedge HCLK); #1;
      chk("bp_hold", 64'({subkey, roundNum, passNum}), 64'({hold_sk, 4'd7, 2'd1}));
    end
    enable = 1'b1;
    key1 = ~r1; key2 = ~r2; key3 = ~r3; encryptionType = 1'b0;
    subkeyReady = 1'b1;
    @(posedge HCLK); #1;
    enable = 1'b0;
    wait_done(dc);
    chk("bp_drain", 64'(sb.size()), 64'd0);

    // ---- reset mid-ROUND ----
    @(posedge HCLK); #1;
    start(1'b1, r1, r2, r3, 1'b1);
    repeat (10) @(posedge HCLK);
    #1 HRESET = 1'b1;
    #1;
    chk("mid_rst_ctl", 64'({subkeyValid, busy, done, passDecrypt, keyError, roundNum, passNum}), 64'd0);
    chk("mid_rst_subkey", 64'(subkey), 64'd0);
    @(negedge HCLK);
    sb.delete();
    @(posedge HCLK); #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("post_rst_idle", 64'({busy, done, subkeyValid}), 64'd0);

`ifdef TDES_KEY_PARITY_CHECK_EN
    // ---- parity rejection then recovery ----
    @(posedge HCLK); #1;
    start(1'b1, K_STD, 64'd0, K_STD, 1'b0);
    repeat (2) @(negedge HCLK);
    chk("par_reject", 64'({keyError, busy, subkeyValid}), 64'b100);
    @(posedge HCLK); #1;
    start(1'b1, K_STD, K_STD, K_STD, 1'b1);
    chk("par_clear", 64'({keyError, busy}), 64'b01);
    wait_done(dc);
    chk("par_drain", 64'(sb.size()), 64'd0);
`else
    // Without the parity gate a zero key still runs to completion.
    @(posedge HCLK); #1;
    start(1'b1, K_STD, 64'd0, K_STD, 1'b1);
    chk("nopar_run", 64'({keyError, busy}), 64'b01);
    wait_done(dc);
    chk("nopar_drain", 64'(sb.size()), 64'd0);
`endif

    repeat (2) @(posedge HCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
